// File: rtl/uni_arbiter.sv
// N-to-1 uni bus arbiter: picks one upstream requester at a time, latches its
// request toward the shared downstream slave and routes the completion back.
module uni_arbiter #(
  parameter int N_MST     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_MST-1:0]           s_valid,
  output logic [N_MST-1:0]           s_ready,
  input  logic [N_MST-1:0]           s_reqtyp,
  input  logic [N_MST*ADDR_W-1:0]    s_addr,
  input  logic [N_MST*DATA_W-1:0]    s_wdata,
  input  logic [N_MST*2-1:0]         s_size,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_resp,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_reqtyp,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [1:0]                 m_size,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_resp,
  output logic [N_MST-1:0]           o_grant
);

  localparam int PTR_W = $clog2(N_MST);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_MST - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  ptr_after;
  logic [CNT_W-1:0]  cnt;
  logic [N_MST-1:0]  grant;
  logic              found;
  logic              any_valid;
  logic              done;
  logic              timeout_hit;
  logic              sel_typ;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;

  // Round-robin searches indices at or above rr_ptr first, then wraps to the
  // low indices; fixed priority uses only the wrap pass, so index 0 wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < N_MST; i++) begin
        if (!found && s_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
          win   = PTR_W'(i);
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_MST; i++) begin
      if (!found && s_valid[i]) begin
        win   = PTR_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_typ   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (win == PTR_W'(i)) begin
        sel_typ   = s_reqtyp[i];
        sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        sel_size  = s_size[i*2 +: 2];
      end
    end
  end

  assign any_valid   = |s_valid;
  assign done        = (state == BUSY) && m_ready;
  assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && !m_ready && (cnt == CNT_LAST);
  assign ptr_after   = (gidx == PTR_LAST) ? '0 : gidx + PTR_W'(1);
  assign o_grant     = grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY: begin
        if (done)             state_nxt = IDLE;
        else if (timeout_hit) state_nxt = DRAIN;
      end
      DRAIN:   if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion and timeout replies are combinational in the BUSY cycle; reset
  // suppresses them so an aborted transfer never reaches a requester.
  always_comb begin
    m_valid = (state != IDLE);
    s_ready = '0;
    s_rdata = '0;
    s_resp  = 2'b00;
    if (!i_rst) begin
      if (done) begin
        s_ready = grant;
        s_rdata = m_rdata;
        s_resp  = m_resp;
      end else if (timeout_hit) begin
        s_ready = grant;
        s_resp  = 2'b11;
      end
    end
  end

  // Request fields are captured once at arbitration and held until the next
  // grant, so the downstream side sees a stable request through BUSY and DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr   <= '0;
      gidx     <= '0;
      cnt      <= '0;
      grant    <= '0;
      m_reqtyp <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_size   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            m_reqtyp <= sel_typ;
            m_addr   <= sel_addr;
            m_wdata  <= sel_wdata;
            m_size   <= sel_size;
            grant    <= {{(N_MST-1){1'b0}}, 1'b1} << win;
            gidx     <= win;
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          if (done || timeout_hit)  rr_ptr <= ptr_after;
          if (done)                 grant <= '0;
        end
        DRAIN: begin
          if (m_ready) grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uni_arbiter.sv
// Bench for uni_arbiter: a round-robin/timeout instance (a) and a fixed-priority
// instance (b), each checked every cycle against a transaction-level model.
module tb_uni_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, rst_b;
  logic [N-1:0]    sv_a, st_a, sr_a, g_a, sv_b, st_b, sr_b, g_b;
  logic [N*AW-1:0] sa_a, sa_b;
  logic [N*DW-1:0] sw_a, sw_b;
  logic [N*2-1:0]  sz_a, sz_b;
  logic [DW-1:0]   rd_a, rd_b, mw_a, mw_b, md_a, md_b;
  logic [1:0]      rs_a, rs_b, mz_a, mz_b, mp_a, mp_b;
  logic            mv_a, mv_b, mr_a, mr_b, mt_a, mt_b;
  logic [AW-1:0]   ma_a, ma_b;

  uni_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(4)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .s_valid(sv_a), .s_ready(sr_a), .s_reqtyp(st_a),
    .s_addr(sa_a), .s_wdata(sw_a), .s_size(sz_a), .s_rdata(rd_a), .s_resp(rs_a),
    .m_valid(mv_a), .m_ready(mr_a), .m_reqtyp(mt_a), .m_addr(ma_a), .m_wdata(mw_a),
    .m_size(mz_a), .m_rdata(md_a), .m_resp(mp_a), .o_grant(g_a));

  uni_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .s_valid(sv_b), .s_ready(sr_b), .s_reqtyp(st_b),
    .s_addr(sa_b), .s_wdata(sw_b), .s_size(sz_b), .s_rdata(rd_b), .s_resp(rs_b),
    .m_valid(mv_b), .m_ready(mr_b), .m_reqtyp(mt_b), .m_addr(ma_b), .m_wdata(mw_b),
    .m_size(mz_b), .m_rdata(md_b), .m_resp(mp_b), .o_grant(g_b));

  int nvec = 0;
  int nerr = 0;
  bit model_on = 1'b0;

  // Model state per instance: phase 0 idle, 1 waiting on slave, 2 draining
  int cfg_prio[2] = '{0, 1};
  int cfg_tmo[2]  = '{4, 0};
  int ph[2]       = '{0, 0};
  int own[2]      = '{0, 0};
  int age[2]      = '{0, 0};
  int ptr[2]      = '{0, 0};
  logic          lt_typ[2];
  logic [AW-1:0] lt_addr[2];
  logic [DW-1:0] lt_wdata[2];
  logic [1:0]    lt_size[2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(
    input int d, input logic rst, input logic [N-1:0] sv, input logic [N-1:0] st,
    input logic [N*AW-1:0] sa, input logic [N*DW-1:0] sw, input logic [N*2-1:0] sz,
    input logic mr, input logic [DW-1:0] md, input logic [1:0] mp,
    input logic [N-1:0] a_sr, input logic [DW-1:0] a_rd, input logic [1:0] a_rs,
    input logic a_mv, input logic a_mt, input logic [AW-1:0] a_ma,
    input logic [DW-1:0] a_mw, input logic [1:0] a_mz, input logic [N-1:0] a_g);
    logic [N-1:0]  e_sr, e_g;
    logic [DW-1:0] e_rd;
    logic [1:0]    e_rs;
    bit            expire;
    int            w, c;
    string         p;
    p      = (d == 0) ? "a" : "b";
    expire = (ph[d] == 1) && !mr && (cfg_tmo[d] > 0) && (age[d] == cfg_tmo[d] - 1);
    e_g    = (ph[d] != 0) ? N'(1 << own[d]) : '0;
    e_sr   = '0;
    e_rd   = '0;
    e_rs   = 2'b00;
    if (!rst && ph[d] == 1 && mr) begin
      e_sr = e_g; e_rd = md; e_rs = mp;
    end else if (!rst && expire) begin
      e_sr = e_g; e_rs = 2'b11;
    end
    checkOutput({p, "_m_valid"}, 64'(a_mv), 64'(ph[d] != 0));
    checkOutput({p, "_o_grant"}, 64'(a_g), 64'(e_g));
    checkOutput({p, "_s_ready"}, 64'(a_sr), 64'(e_sr));
    if (e_sr != 0) begin
      checkOutput({p, "_s_rdata"}, a_rd, e_rd);
      checkOutput({p, "_s_resp"}, 64'(a_rs), 64'(e_rs));
    end
    if (ph[d] != 0) begin
      checkOutput({p, "_m_reqtyp"}, 64'(a_mt), 64'(lt_typ[d]));
      checkOutput({p, "_m_addr"}, 64'(a_ma), 64'(lt_addr[d]));
      checkOutput({p, "_m_wdata"}, a_mw, lt_wdata[d]);
      checkOutput({p, "_m_size"}, 64'(a_mz), 64'(lt_size[d]));
    end
    if (rst) begin
      ph[d] = 0; ptr[d] = 0; age[d] = 0;
      lt_typ[d] = 1'b0; lt_addr[d] = '0; lt_wdata[d] = '0; lt_size[d] = '0;
    end else if (ph[d] == 0) begin
      if (sv != 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          c = (cfg_prio[d] != 0) ? k : (ptr[d] + k) % N;
          if (w < 0 && sv[c]) w = c;
        end
        own[d] = w; ph[d] = 1; age[d] = 0;
        lt_typ[d]   = st[w];
        lt_addr[d]  = sa[w*AW +: AW];
        lt_wdata[d] = sw[w*DW +: DW];
        lt_size[d]  = sz[w*2 +: 2];
      end
    end else if (ph[d] == 1) begin
      if (mr) begin
        ph[d] = 0; ptr[d] = (own[d] + 1) % N;
      end else if (expire) begin
        ph[d] = 2; ptr[d] = (own[d] + 1) % N;
      end else begin
        age[d]++;
      end
    end else if (mr) begin
      ph[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      model_cycle(0, rst_a, sv_a, st_a, sa_a, sw_a, sz_a, mr_a, md_a, mp_a,
                  sr_a, rd_a, rs_a, mv_a, mt_a, ma_a, mw_a, mz_a, g_a);
      model_cycle(1, rst_b, sv_b, st_b, sa_b, sw_b, sz_b, mr_b, md_b, mp_b,
                  sr_b, rd_b, rs_b, mv_b, mt_b, ma_b, mw_b, mz_b, g_b);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sv_a = '0; st_a = '0; sa_a = '0; sw_a = '0; sz_a = '0; mr_a = 1'b0; md_a = '0; mp_a = '0;
    sv_b = '0; st_b = '0; sa_b = '0; sw_b = '0; sz_b = '0; mr_b = 1'b0; md_b = '0; mp_b = '0;
    applyStimulus;
    model_on = 1'b1;
    applyStimulus;
    @(negedge clk);
    checkOutput("rst_m_valid", 64'(mv_a), 64'd0);
    checkOutput("rst_s_ready", 64'(sr_a), 64'd0);
    checkOutput("rst_o_grant", 64'(g_a), 64'd0);
    checkOutput("rst_m_addr", 64'(ma_a), 64'd0);
    checkOutput("rst_s_rdata", rd_a, 64'd0);
    checkOutput("rst_s_resp", 64'(rs_a), 64'd0);

    // Single write on requester 0, slave answers on the third BUSY cycle
    applyStimulus;
    rst_a = 1'b0; rst_b = 1'b0;
    sv_a = 3'b001; st_a = 3'b001;
    sa_a[0 +: AW] = 32'h8000_0000; sw_a[0 +: DW] = 64'hDEAD; sz_a[1:0] = 2'b11;
    applyStimulus;
    @(negedge clk);
    checkOutput("t1_m_valid", 64'(mv_a), 64'd1);
    checkOutput("t1_m_addr", 64'(ma_a), 64'h8000_0000);
    checkOutput("t1_m_wdata", mw_a, 64'hDEAD);
    checkOutput("t1_m_size", 64'(mz_a), 64'd3);
    checkOutput("t1_m_reqtyp", 64'(mt_a), 64'd1);
    checkOutput("t1_o_grant", 64'(g_a), 64'b001);
    checkOutput("t1_early_s_ready", 64'(sr_a), 64'd0);
    applyStimulus;
    applyStimulus;
    mr_a = 1'b1; mp_a = 2'b00;
    @(negedge clk);
    checkOutput("t1_s_ready", 64'(sr_a), 64'b001);
    checkOutput("t1_s_resp", 64'(rs_a), 64'd0);

    // Read on requester 1 with zero-wait slave
    applyStimulus;
    mr_a = 1'b0;
    sv_a = 3'b010; st_a = 3'b000; sa_a[AW +: AW] = 32'h1000;
    @(negedge clk);
    checkOutput("t1_done_m_valid", 64'(mv_a), 64'd0);
    applyStimulus;
    mr_a = 1'b1; md_a = 64'h0123_4567_89AB_CDEF; mp_a = 2'b00;
    @(negedge clk);
    checkOutput("t5_s_ready", 64'(sr_a), 64'b010);
    checkOutput("t5_s_rdata", rd_a, 64'h0123_4567_89AB_CDEF);
    checkOutput("t5_m_addr", 64'(ma_a), 64'h1000);

    // Reset in the middle of a BUSY transfer owned by requester 2
    applyStimulus;
    mr_a = 1'b0; md_a = '0; sv_a = 3'b111;
    applyStimulus;
    @(negedge clk);
    checkOutput("t6_pre_o_grant", 64'(g_a), 64'b100);
    applyStimulus;
    rst_a = 1'b1;
    applyStimulus;
    rst_a = 1'b0; mr_a = 1'b1;
    @(negedge clk);
    checkOutput("t6_m_valid", 64'(mv_a), 64'd0);
    checkOutput("t6_o_grant", 64'(g_a), 64'd0);
    checkOutput("t6_s_ready", 64'(sr_a), 64'd0);

    // All requesters held, zero-wait slave: grants rotate 0,1,2 every other cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus;
      @(negedge clk);
      checkOutput($sformatf("t2_grant_%0d", k), 64'(g_a), 64'(1 << (k % 3)));
      checkOutput($sformatf("t2_ready_%0d", k), 64'(sr_a), 64'(1 << (k % 3)));
      applyStimulus;
      if (k == 5) begin
        sv_a = '0; mr_a = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("t2_idle_%0d", k), 64'(g_a), 64'd0);
    end

    // Stalled slave: error reply on the 4th BUSY cycle, then drain until +10
    applyStimulus;
    sv_a = 3'b001; st_a = 3'b000; sa_a[0 +: AW] = 32'h2000;
    md_a = 64'hFFFF_FFFF_FFFF_FFFF; mp_a = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      applyStimulus;
      @(negedge clk);
      checkOutput($sformatf("t4_wait_%0d", c), 64'(sr_a), 64'd0);
    end
    applyStimulus;
    @(negedge clk);
    checkOutput("t4_s_ready", 64'(sr_a), 64'b001);
    checkOutput("t4_s_resp", 64'(rs_a), 64'd3);
    checkOutput("t4_s_rdata", rd_a, 64'd0);
    for (int c = 5; c <= 10; c++) begin
      applyStimulus;
      sv_a = '0;
      if (c == 10) begin
        mr_a = 1'b1; mp_a = 2'b10;
      end
      @(negedge clk);
      checkOutput($sformatf("t4_drain_valid_%0d", c), 64'(mv_a), 64'd1);
      checkOutput($sformatf("t4_drain_ready_%0d", c), 64'(sr_a), 64'd0);
    end
    applyStimulus;
    mr_a = 1'b0;
    @(negedge clk);
    checkOutput("t4_idle_m_valid", 64'(mv_a), 64'd0);
    checkOutput("t4_idle_s_ready", 64'(sr_a), 64'd0);

    // Fixed priority: requester 0 starves requester 2
    applyStimulus;
    sv_b = 3'b101; mr_b = 1'b1;
    sa_b[0 +: AW] = 32'h40; sa_b[2*AW +: AW] = 32'h42;
    for (int k = 0; k < 4; k++) begin
      applyStimulus;
      @(negedge clk);
      checkOutput($sformatf("t3_grant_%0d", k), 64'(g_b), 64'b001);
      checkOutput($sformatf("t3_m_addr_%0d", k), 64'(ma_b), 64'h40);
      applyStimulus;
      @(negedge clk);
      checkOutput($sformatf("t3_idle_%0d", k), 64'(g_b), 64'd0);
    end
    sv_b = '0; mr_b = 1'b0;
    applyStimulus;
    applyStimulus;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
